// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants, AFC codes and FSM state type for the TS packet generator
package ts_pkg;
  localparam logic [7:0] TS_SYNC_BYTE  = 8'h47;
  localparam int         TS_PACKET_LEN = 188;
  localparam int         TS_HEADER_LEN = 4;
  localparam logic [7:0] TS_STUFF_BYTE = 8'hFF;

  localparam logic [1:0] AFC_RESERVED      = 2'b00;
  localparam logic [1:0] AFC_PAYLOAD_ONLY  = 2'b01;
  localparam logic [1:0] AFC_ADAPT_ONLY    = 2'b10;
  localparam logic [1:0] AFC_ADAPT_PAYLOAD = 2'b11;

  // Byte positions within a packet, counted from the sync byte.
  localparam logic [7:0] HDR_LAST_IDX = 8'(TS_HEADER_LEN - 1);
  localparam logic [7:0] AF_IDX       = 8'(TS_HEADER_LEN);
  localparam logic [7:0] LAST_IDX     = 8'(TS_PACKET_LEN - 1);
  localparam logic [7:0] AF_LEN_FULL  = 8'(TS_PACKET_LEN - TS_HEADER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    ADAPT,
    PAYLOAD
  } ts_state_e;
endpackage

// File: rtl/ts_header_builder.sv
// rtl/ts_header_builder.sv - combinational selector for the four TS header bytes
module ts_header_builder
  import ts_pkg::*;
(
  input  logic [12:0] pid,
  input  logic        pusi,
  input  logic [1:0]  afc,
  input  logic [3:0]  cc,
  input  logic [1:0]  byte_index,
  output logic [7:0]  hdr_byte
);

  always_comb begin
    hdr_byte = TS_SYNC_BYTE;
    case (byte_index)
      2'd0: hdr_byte = TS_SYNC_BYTE;
      2'd1: hdr_byte = {1'b0, pusi, 1'b0, pid[12:8]};
      2'd2: hdr_byte = pid[7:0];
      2'd3: hdr_byte = {2'b00, afc, cc};
      default: hdr_byte = TS_SYNC_BYTE;
    endcase
  end

endmodule

// File: rtl/ts_packet_generator.sv
// rtl/ts_packet_generator.sv - 188-byte MPEG-TS packet generator; TS_CC_ERROR_INJECT_EN adds cc error injection
module ts_packet_generator
  import ts_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef TS_CC_ERROR_INJECT_EN
  input  logic        inject_cc_error,
`endif
  input  logic        start,
  input  logic [12:0] pid,
  input  logic [1:0]  afc,
  input  logic        pusi,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  ts_data,
  output logic        valid,
  output logic        sync,
  output logic        busy,
  output logic [7:0]  packet_count
);

  ts_state_e   state, state_next;
  logic [7:0]  idx;
  logic [12:0] pid_q;
  logic [1:0]  afc_q;
  logic        pusi_q;
  logic [3:0]  cc;
  logic [3:0]  cc_step;
  logic        step;
  logic        last;
  logic [7:0]  out_byte;
  logic [7:0]  hdr_byte;

  ts_header_builder u_header_builder (
    .pid        (pid_q),
    .pusi       (pusi_q),
    .afc        (afc_q),
    .cc         (cc),
    .byte_index (idx[1:0]),
    .hdr_byte   (hdr_byte)
  );

  // A packet being aborted by reset must not swallow a payload byte.
  assign payload_ready = (state == PAYLOAD) && !reset;
  assign busy          = (state != IDLE);
  assign last          = step && (idx == LAST_IDX);

`ifdef TS_CC_ERROR_INJECT_EN
  logic inject_armed;

  assign cc_step = inject_armed ? 4'd2 : 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      inject_armed <= 1'b0;
    end else if (inject_cc_error) begin
      inject_armed <= 1'b1;
    end else if (last && afc_q[0]) begin
      inject_armed <= 1'b0;
    end
  end
`else
  assign cc_step = 4'd1;
`endif

  always_comb begin
    state_next = state;
    step       = 1'b0;
    out_byte   = TS_STUFF_BYTE;
    case (state)
      IDLE: begin
        if (start) state_next = HEADER;
      end
      HEADER: begin
        step     = 1'b1;
        out_byte = hdr_byte;
        if (idx == HDR_LAST_IDX)
          state_next = (afc_q == AFC_PAYLOAD_ONLY) ? PAYLOAD : ADAPT;
      end
      ADAPT: begin
        step = 1'b1;
        if (idx == AF_IDX) begin
          case (afc_q)
            AFC_ADAPT_PAYLOAD: out_byte = 8'h00;
            AFC_ADAPT_ONLY:    out_byte = AF_LEN_FULL;
            AFC_RESERVED:      out_byte = TS_STUFF_BYTE;
            default:           out_byte = TS_STUFF_BYTE;
          endcase
        end
        // An empty adaptation field is a single length byte before payload.
        if (afc_q == AFC_ADAPT_PAYLOAD)
          state_next = PAYLOAD;
        else if (idx == LAST_IDX)
          state_next = IDLE;
      end
      PAYLOAD: begin
        step     = payload_valid;
        out_byte = payload_data;
        if (payload_valid && (idx == LAST_IDX)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 8'd0;
      pid_q        <= 13'd0;
      afc_q        <= 2'b00;
      pusi_q       <= 1'b0;
      cc           <= 4'd0;
      packet_count <= 8'd0;
      ts_data      <= 8'd0;
      valid        <= 1'b0;
      sync         <= 1'b0;
    end else begin
      state <= state_next;
      valid <= step;
      sync  <= step && (state == HEADER) && (idx == 8'd0);
      if (step) ts_data <= out_byte;

      if ((state == IDLE) && start) begin
        pid_q  <= pid;
        afc_q  <= afc;
        pusi_q <= pusi;
        idx    <= 8'd0;
      end else if (step) begin
        idx <= idx + 8'd1;
      end

      if (last) begin
        packet_count <= packet_count + 8'd1;
        if (afc_q[0]) cc <= cc + cc_step;
      end
    end
  end

endmodule
